// File: rtl/imm_ext_pkg.sv
// Shared types, default widths and the immediate-extension function for imm_extend_pipe.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    IMM_ZERO   = 2'd0,
    IMM_SIGN   = 2'd1,
    IMM_UPPER  = 2'd2,
    IMM_SHIFT2 = 2'd3
  } immMode_e;

  localparam int unsigned DEF_IN_W  = 16;
  localparam int unsigned DEF_OUT_W = 32;
  localparam int unsigned DEF_TAG_W = 5;
  localparam int unsigned EXT_MAX_W = 64;

  // Pure extension at the widest supported size; callers truncate to their operand width.
  function automatic logic [EXT_MAX_W-1:0] extendImm(
    input logic [EXT_MAX_W-1:0] data,
    input immMode_e             mode,
    input int unsigned          inW,
    input int unsigned          outW
  );
    logic [EXT_MAX_W-1:0] inMask;
    logic [EXT_MAX_W-1:0] zext;
    logic [EXT_MAX_W-1:0] sext;
    logic [EXT_MAX_W-1:0] res;
    inMask = (EXT_MAX_W'(1) << inW) - EXT_MAX_W'(1);
    zext   = data & inMask;
    sext   = data[6'(inW - 1)] ? (zext | ~inMask) : zext;
    case (mode)
      IMM_ZERO:   res = zext;
      IMM_SIGN:   res = sext;
      IMM_UPPER:  res = zext << (outW - inW);
      IMM_SHIFT2: res = sext << 2;
      default:    res = zext;
    endcase
    return res & ((EXT_MAX_W'(1) << outW) - EXT_MAX_W'(1));
  endfunction

endpackage

// File: rtl/imm_ext_skid.sv
// Output register plus one-entry skid buffer; upReady is a flop so no downstream ready path reaches upstream.
module imm_ext_skid
  import imm_ext_pkg::*;
#(
  parameter int unsigned W = DEF_OUT_W + DEF_TAG_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         upValid,
  output logic         upReady,
  input  logic [W-1:0] upData,
  output logic         dnValid,
  input  logic         dnReady,
  output logic [W-1:0] dnData
);

  logic         skidEmptyQ;
  logic [W-1:0] skidDataQ;
  logic         dnValidQ;
  logic [W-1:0] dnDataQ;
  logic         accept;
  logic         dnFree;

  assign upReady = skidEmptyQ;
  assign dnValid = dnValidQ;
  assign dnData  = dnDataQ;
  assign accept  = upValid && skidEmptyQ;
  assign dnFree  = !dnValidQ || dnReady;

  // A held skid beat always refills the output before any new input is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skidEmptyQ <= 1'b1;
      skidDataQ  <= '0;
      dnValidQ   <= 1'b0;
      dnDataQ    <= '0;
    end else if (flush) begin
      skidEmptyQ <= 1'b1;
      dnValidQ   <= 1'b0;
    end else if (dnFree) begin
      if (!skidEmptyQ) begin
        dnDataQ    <= skidDataQ;
        dnValidQ   <= 1'b1;
        skidEmptyQ <= 1'b1;
      end else begin
        dnValidQ <= accept;
        if (accept) dnDataQ <= upData;
      end
    end else if (accept) begin
      skidDataQ  <= upData;
      skidEmptyQ <= 1'b0;
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate-extension unit with valid/ready handshake and synchronous flush.
// Define IMM_EXT_SKID_EN to insert a one-entry skid buffer and register in_ready.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OUT_W = DEF_OUT_W,
  parameter int unsigned TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  logic [OUT_W-1:0] extData;

  // All arithmetic sits in front of the register; the output side only moves data.
  assign extData = OUT_W'(extendImm(EXT_MAX_W'(in_data), immMode_e'(in_mode), IN_W, OUT_W));

`ifdef IMM_EXT_SKID_EN
  logic [OUT_W+TAG_W-1:0] dnPayload;

  imm_ext_skid #(
    .W (OUT_W + TAG_W)
  ) uSkid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .upValid (in_valid),
    .upReady (in_ready),
    .upData  ({extData, in_tag}),
    .dnValid (out_valid),
    .dnReady (out_ready),
    .dnData  (dnPayload)
  );

  assign out_data = dnPayload[OUT_W+TAG_W-1:TAG_W];
  assign out_tag  = dnPayload[TAG_W-1:0];
`else
  logic             outValidQ;
  logic [OUT_W-1:0] outDataQ;
  logic [TAG_W-1:0] outTagQ;
  logic             load;

  assign in_ready  = !outValidQ || out_ready;
  assign load      = in_valid && in_ready && !flush;
  assign out_valid = outValidQ;
  assign out_data  = outDataQ;
  assign out_tag   = outTagQ;

  // Data/tag move only on a real load so a stalled or flushed output stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValidQ <= 1'b0;
      outDataQ  <= '0;
      outTagQ   <= '0;
    end else begin
      if (flush)         outValidQ <= 1'b0;
      else if (in_ready) outValidQ <= in_valid;
      if (load) begin
        outDataQ <= extData;
        outTagQ  <= in_tag;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe (default widths plus an IN_W=8/OUT_W=16 instance).
module tb_imm_extend_pipe;

`ifdef IMM_EXT_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  logic        v8, r8, ov8, or8, flush8;
  logic [7:0]  d8;
  logic [1:0]  m8;
  logic [4:0]  t8, ot8;
  logic [15:0] od8;

  int tests = 0;
  int fails = 0;

  // Model: FIFO of in-flight results (capacity 1 without skid, 2 with) and the last value shown.
  logic [63:0] qd[$];
  int          qt[$];
  int          popped[$];
  logic [63:0] heldD;
  int          heldT;
  bit          lastAcc;
  int          runLen, maxRun;

  always #5 clk = ~clk;

  imm_extend_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  imm_extend_pipe #(.IN_W(8), .OUT_W(16), .TAG_W(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush8),
    .in_valid(v8), .in_ready(r8), .in_data(d8), .in_mode(m8), .in_tag(t8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_tag(ot8)
  );

  // Extension from the arithmetic meaning of each mode.
  function automatic logic [63:0] refExt(input logic [63:0] d, input int m, input int inW, input int outW);
    logic [63:0] modOut, s;
    modOut = 64'd1 << outW;
    s = (d >= (64'd1 << (inW - 1))) ? d + modOut - (64'd1 << inW) : d;
    case (m)
      0:       return d;
      1:       return s;
      2:       return (d * (64'd1 << (outW - inW))) % modOut;
      default: return (s * 64'd4) % modOut;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic modelClear();
    qd.delete();
    qt.delete();
  endtask

  // One clock: inputs are already driven; check, then advance the model at the edge.
  task automatic cyc();
    logic expReady, pop;
    #1;
    chk("out_valid", 64'(out_valid), 64'(qd.size() > 0));
    chk("out_data", 64'(out_data), heldD);
    chk("out_tag", 64'(out_tag), 64'(heldT));
    expReady = SKID ? (qd.size() < 2) : (qd.size() == 0 || out_ready);
    chk("in_ready", 64'(in_ready), 64'(expReady));
    if (out_valid) runLen++; else runLen = 0;
    if (runLen > maxRun) maxRun = runLen;
    lastAcc = in_valid && expReady && !flush;
    pop = (qd.size() > 0) && out_ready;
    @(posedge clk);
    if (flush) modelClear();
    else begin
      if (pop) begin
        popped.push_back(qt[0]);
        void'(qd.pop_front());
        void'(qt.pop_front());
      end
      if (lastAcc) begin
        qd.push_back(refExt(64'(in_data), int'(in_mode), 16, 32));
        qt.push_back(int'(in_tag));
      end
    end
    if (qd.size() > 0) begin
      heldD = qd[0];
      heldT = qt[0];
    end
    @(negedge clk);
  endtask

  logic [15:0] dirData[5] = '{16'hFFFB, 16'hFFFB, 16'h1234, 16'hFFFF, 16'h2710};
  logic [1:0]  dirMode[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
  logic [31:0] dirExp[5]  = '{32'h0000FFFB, 32'hFFFFFFFB, 32'h12340000, 32'hFFFFFFFC, 32'h00002710};

  initial begin
    int idx;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; in_tag = '0; out_ready = 1'b1;
    v8 = 1'b0; d8 = '0; m8 = '0; t8 = '0; or8 = 1'b1; flush8 = 1'b0;
    heldD = '0; heldT = 0; runLen = 0; maxRun = 0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    cyc();

    // Directed modes, one per cycle, tag echoed.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = dirData[i]; in_mode = dirMode[i]; in_tag = 5'(i + 10);
      cyc();
      chk($sformatf("mode_lit%0d", i), 64'(out_data), 64'(dirExp[i]));
      chk($sformatf("tag_lit%0d", i), 64'(out_tag), 64'(i + 10));
    end
    in_valid = 1'b0;
    cyc(); cyc();

    // Back-pressure: tags 1..6 with a 3-cycle stall mid-stream.
    popped.delete();
    idx = 1;
    for (int c = 0; c < 30; c++) begin
      in_valid  = (idx <= 6);
      in_data   = 16'($urandom);
      in_mode   = 2'($urandom);
      in_tag    = 5'(idx);
      out_ready = !(c >= 3 && c < 6);
      cyc();
      if (lastAcc) idx++;
    end
    chk("bp_count", 64'(popped.size()), 64'd6);
    for (int i = 0; i < 6 && i < popped.size(); i++)
      chk($sformatf("bp_order%0d", i), 64'(popped[i]), 64'(i + 1));

    // Throughput: 8 back-to-back inputs with out_ready high.
    in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    runLen = 0; maxRun = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 16'($urandom); in_mode = 2'($urandom); in_tag = 5'(i);
      cyc();
    end
    in_valid = 1'b0;
    cyc(); cyc(); cyc();
    chk("throughput_run", 64'(maxRun), 64'd8);

    // Flush with the output (and skid) full and an input offered in the flush cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'(16'h0100 + i); in_mode = 2'd0; in_tag = 5'(20 + i);
      cyc();
    end
    flush = 1'b1; in_data = 16'h0777; in_tag = 5'd30;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    #1 chk("flush_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    cyc();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h8001; in_mode = 2'd1; in_tag = 5'd31;
    cyc();
    in_valid = 1'b0;
    chk("post_flush_data", 64'(out_data), 64'hFFFF8001);
    chk("post_flush_tag", 64'(out_tag), 64'd31);
    cyc();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(15) == 0);
      in_data   = 16'($urandom);
      in_mode   = 2'($urandom);
      in_tag    = 5'($urandom);
      cyc();
    end
    flush = 1'b0;

    // Asynchronous reset mid-stream.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h4321; in_mode = 2'd2; in_tag = 5'd7;
    cyc(); cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    chk("arst_out_tag", 64'(out_tag), 64'd0);
    modelClear(); heldD = '0; heldT = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cyc();
    in_valid = 1'b1; in_data = 16'h00F0; in_mode = 2'd3; in_tag = 5'd3;
    cyc();
    in_valid = 1'b0;
    cyc();

    // Narrow instance: IN_W=8, OUT_W=16.
    v8 = 1'b1; d8 = 8'h80; m8 = 2'd1; t8 = 5'd9;
    @(posedge clk); #1;
    chk("w8_sign", 64'(od8), 64'hFF80);
    chk("w8_sign_model", 64'(od8), refExt(64'h80, 1, 8, 16));
    chk("w8_tag", 64'(ot8), 64'd9);
    @(negedge clk);
    d8 = 8'hC0; m8 = 2'd3; t8 = 5'd4;
    @(posedge clk); #1;
    chk("w8_shift2", 64'(od8), 64'hFF00);
    chk("w8_shift2_model", 64'(od8), refExt(64'hC0, 3, 8, 16));
    chk("w8_valid", 64'(ov8), 64'd1);
    @(negedge clk);
    v8 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
